// File: rtl/ysyx_041461_lsu_pkg.sv
// ysyx_041461_lsu_pkg: shared LSU op encodings, trap codes, FSM state
// encoding and access-size helpers used by the LSU and its aligner.
package ysyx_041461_lsu_pkg;

   typedef enum logic [3:0] {
      LSU_NOP = 4'd0,
      LSU_LB  = 4'd1,
      LSU_LH  = 4'd2,
      LSU_LW  = 4'd3,
      LSU_LD  = 4'd4,
      LSU_LBU = 4'd5,
      LSU_LHU = 4'd6,
      LSU_LWU = 4'd7,
      LSU_SB  = 4'd8,
      LSU_SH  = 4'd9,
      LSU_SW  = 4'd10,
      LSU_SD  = 4'd11
   } lsu_op_e;

   localparam logic [3:0] TRAP_NOP            = 4'd0;
   localparam logic [3:0] TRAP_LOAD_MISALIGN  = 4'd4;
   localparam logic [3:0] TRAP_STORE_MISALIGN = 4'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

   function automatic logic lsu_is_load(input logic [3:0] ctrl);
      logic r;
      case (ctrl)
         LSU_LB, LSU_LH, LSU_LW, LSU_LD,
         LSU_LBU, LSU_LHU, LSU_LWU: r = 1'b1;
         default:                   r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic lsu_is_store(input logic [3:0] ctrl);
      logic r;
      case (ctrl)
         LSU_SB, LSU_SH, LSU_SW, LSU_SD: r = 1'b1;
         default:                        r = 1'b0;
      endcase
      return r;
   endfunction

   // log2 of the access size in bytes (0 for non-memory ops)
   function automatic logic [1:0] lsu_size_log2(input logic [3:0] ctrl);
      logic [1:0] r;
      case (ctrl)
         LSU_LB, LSU_LBU, LSU_SB: r = 2'd0;
         LSU_LH, LSU_LHU, LSU_SH: r = 2'd1;
         LSU_LW, LSU_LWU, LSU_SW: r = 2'd2;
         LSU_LD, LSU_SD:          r = 2'd3;
         default:                 r = 2'd0;
      endcase
      return r;
   endfunction

   // Byte offset with the low bits cleared down to the access size
   function automatic logic [2:0] lsu_eff_offset(input logic [3:0] ctrl, input logic [2:0] a);
      logic [2:0] r;
      case (lsu_size_log2(ctrl))
         2'd0:    r = a;
         2'd1:    r = {a[2:1], 1'b0};
         2'd2:    r = {a[2], 2'b00};
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   // True when the byte offset is not a multiple of the access size
   function automatic logic lsu_misaligned(input logic [3:0] ctrl, input logic [2:0] a);
      logic r;
      case (lsu_size_log2(ctrl))
         2'd1:    r = a[0];
         2'd2:    r = |a[1:0];
         2'd3:    r = |a;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ysyx_041461_lsu_align.sv
// ysyx_041461_lsu_align: combinational byte-lane steering. Produces store
// strobes and lane-shifted store data, and the aligned, extended load value.
module ysyx_041461_lsu_align
   import ysyx_041461_lsu_pkg::*;
(
   input  logic [3:0]  ctrl,
   input  logic [2:0]  a,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [7:0]  wmask,
   output logic [63:0] wdata_sh,
   output logic [63:0] load_data
);

   logic [63:0] rdata_sh;

   // Place store data on its byte lanes and select the matching strobes.
   always_comb begin
      wdata_sh = wdata << {a, 3'b000};
      case (ctrl)
         LSU_SB:  wmask = 8'h01 << a;
         LSU_SH:  wmask = 8'h03 << a;
         LSU_SW:  wmask = 8'h0F << a;
         LSU_SD:  wmask = 8'hFF;
         default: wmask = 8'h00;
      endcase
   end

   // Bring the addressed bytes down to bit 0, then sign- or zero-extend.
   always_comb begin
      rdata_sh = rdata >> {a, 3'b000};
      case (ctrl)
         LSU_LB:  load_data = {{56{rdata_sh[7]}}, rdata_sh[7:0]};
         LSU_LH:  load_data = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
         LSU_LW:  load_data = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
         LSU_LD:  load_data = rdata_sh;
         LSU_LBU: load_data = {56'h0, rdata_sh[7:0]};
         LSU_LHU: load_data = {48'h0, rdata_sh[15:0]};
         LSU_LWU: load_data = {32'h0, rdata_sh[31:0]};
         default: load_data = 64'h0;
      endcase
   end

endmodule

// File: rtl/ysyx_041461_lsu.sv
// ysyx_041461_lsu: load/store stage between execute and writeback.
// One memory request in flight at a time; registered outputs throughout.
// Optional feature macro YSYX_041461_LSU_MISALIGN_TRAP_EN: when defined a
// misaligned access traps (4 load / 6 store) instead of being masked down.
module ysyx_041461_lsu
   import ysyx_041461_lsu_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [63:0]         in_pc,
   input  logic [3:0]          in_trap,
   input  logic [3:0]          in_ctrl,
   input  logic [ADDR_W-1:0]   in_exe,
   input  logic [DATA_W-1:0]   in_wdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_rdata,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [63:0]         out_pc,
   output logic [3:0]          out_trap,
   output logic [63:0]         out_data
);

   lsu_state_e  state;
   logic [3:0]  ctrl_q;
   logic [2:0]  off_q;

   logic [3:0]  align_ctrl;
   logic [2:0]  align_off;
   logic [7:0]  align_wmask;
   logic [63:0] align_wdata;
   logic [63:0] align_load;
   logic        is_mem;
   logic        misalign;

   // Steer the aligner: the incoming op while idle, the latched op afterwards.
   always_comb begin
      if (state == S_IDLE) begin
         align_ctrl = in_ctrl;
         align_off  = lsu_eff_offset(in_ctrl, in_exe[2:0]);
      end else begin
         align_ctrl = ctrl_q;
         align_off  = off_q;
      end
   end

   // Classify the incoming op: memory access and whether it must trap as misaligned.
   always_comb begin
      is_mem = lsu_is_load(in_ctrl) | lsu_is_store(in_ctrl);
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
      misalign = lsu_misaligned(in_ctrl, in_exe[2:0]);
`else
      misalign = 1'b0;
`endif
   end

   ysyx_041461_lsu_align u_align (
      .ctrl      (align_ctrl),
      .a         (align_off),
      .wdata     (in_wdata),
      .rdata     (mem_rsp_rdata),
      .wmask     (align_wmask),
      .wdata_sh  (align_wdata),
      .load_data (align_load)
   );

   // Stage FSM: accept, issue request, await response, hand off result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         ctrl_q        <= 4'd0;
         off_q         <= 3'd0;
         in_ready      <= 1'b1;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wen   <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
         out_valid     <= 1'b0;
         out_pc        <= 64'h0;
         out_trap      <= 4'd0;
         out_data      <= 64'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  out_pc   <= in_pc;
                  ctrl_q   <= in_ctrl;
                  off_q    <= align_off;
                  if (in_trap != TRAP_NOP) begin
                     // Upstream trap wins over everything and suppresses memory
                     out_trap  <= in_trap;
                     out_data  <= 64'h0;
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end else if (!is_mem) begin
                     out_trap  <= TRAP_NOP;
                     out_data  <= in_exe;
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end else if (misalign) begin
                     out_trap  <= lsu_is_store(in_ctrl) ? TRAP_STORE_MISALIGN : TRAP_LOAD_MISALIGN;
                     out_data  <= 64'h0;
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     out_trap      <= TRAP_NOP;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= {in_exe[ADDR_W-1:3], 3'b000};
                     mem_req_wen   <= lsu_is_store(in_ctrl);
                     mem_req_wdata <= align_wdata;
                     mem_req_wmask <= align_wmask;
                     state         <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rsp_valid) begin
                  out_data  <= lsu_is_store(ctrl_q) ? 64'h0 : align_load;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state         <= S_IDLE;
               in_ready      <= 1'b1;
               mem_req_valid <= 1'b0;
               out_valid     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_041461_lsu.sv
// tb_ysyx_041461_lsu: table-driven directed vectors, hand sequences for
// reset mid-operation, and randomized ops checked against a byte-level model.
module tb_ysyx_041461_lsu;

   localparam logic [3:0] C_NOP = 4'd0, C_LB = 4'd1, C_LH = 4'd2, C_LW = 4'd3, C_LD = 4'd4;
   localparam logic [3:0] C_LBU = 4'd5, C_LHU = 4'd6, C_LWU = 4'd7;
   localparam logic [3:0] C_SB = 4'd8, C_SH = 4'd9, C_SW = 4'd10, C_SD = 4'd11;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [3:0]  in_trap;
   logic [3:0]  in_ctrl;
   logic [63:0] in_exe;
   logic [63:0] in_wdata;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_req_wen;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [3:0]  out_trap;
   logic [63:0] out_data;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [63:0] pc;
      logic [3:0]  trap;
      logic [3:0]  ctrl;
      logic [63:0] exe;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          req_stall;
      int          rsp_wait;
      int          out_stall;
      logic        exp_mem;
      logic [63:0] exp_addr;
      logic        exp_wen;
      logic [7:0]  exp_wmask;
      logic [63:0] exp_wdata;
      logic [3:0]  exp_trap;
      logic [63:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   ysyx_041461_lsu dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pc         (in_pc),
      .in_trap       (in_trap),
      .in_ctrl       (in_ctrl),
      .in_exe        (in_exe),
      .in_wdata      (in_wdata),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wen   (mem_req_wen),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_wmask (mem_req_wmask),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_trap      (out_trap),
      .out_data      (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: byte-level view of the access, built from size/offset arithmetic
   function automatic void model(input logic [3:0] ctrl, input logic [3:0] trap,
                                 input logic [63:0] exe, input logic [63:0] wdata, input logic [63:0] rdata,
                                 output logic mem, output logic [63:0] addr, output logic wen,
                                 output logic [7:0] wmask, output logic [63:0] wd,
                                 output logic [3:0] otrap, output logic [63:0] odata);
      int n, a;
      bit sgn, st;
      logic [63:0] v;
      n = 0; sgn = 0; st = 0;
      case (ctrl)
         C_LB:  begin n = 1; sgn = 1; end
         C_LH:  begin n = 2; sgn = 1; end
         C_LW:  begin n = 4; sgn = 1; end
         C_LD:  n = 8;
         C_LBU: n = 1;
         C_LHU: n = 2;
         C_LWU: n = 4;
         C_SB:  begin n = 1; st = 1; end
         C_SH:  begin n = 2; st = 1; end
         C_SW:  begin n = 4; st = 1; end
         C_SD:  begin n = 8; st = 1; end
         default: n = 0;
      endcase
      a = int'(exe % 64'd8);
      mem = 1'b0; addr = 64'h0; wen = 1'b0; wmask = 8'h00; wd = 64'h0; otrap = trap; odata = 64'h0;
      if (trap != 4'd0) return;
      if (n == 0) begin
         odata = exe;
         return;
      end
      if (a % n != 0) begin
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
         otrap = st ? 4'd6 : 4'd4;
         return;
`else
         a = a - (a % n);
`endif
      end
      mem  = 1'b1;
      addr = exe - (exe % 64'd8);
      wen  = st;
      if (st) begin
         for (int i = 0; i < n; i++) wmask[a + i] = 1'b1;
         wd = wdata << (8 * a);
      end else begin
         v = 64'h0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(a+i) +: 8];
         if (sgn && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
         odata = v;
      end
   endfunction

   task automatic add_vec(input logic [63:0] pc, input logic [3:0] trap, input logic [3:0] ctrl,
                          input logic [63:0] exe, input logic [63:0] wdata, input logic [63:0] rdata,
                          input int rs, input int rw, input int os,
                          input logic em, input logic [63:0] ea, input logic ew, input logic [7:0] emk,
                          input logic [63:0] ewd, input logic [3:0] et, input logic [63:0] ed);
      vec_t v;
      v.pc = pc; v.trap = trap; v.ctrl = ctrl; v.exe = exe; v.wdata = wdata; v.rdata = rdata;
      v.req_stall = rs; v.rsp_wait = rw; v.out_stall = os;
      v.exp_mem = em; v.exp_addr = ea; v.exp_wen = ew; v.exp_wmask = emk; v.exp_wdata = ewd;
      v.exp_trap = et; v.exp_data = ed;
      vecs.push_back(v);
   endtask

   // Drive one op through the stage and check every observable step of it
   task automatic run_op(input string tag, input vec_t v);
      int cyc;
      int exp_lat;
      @(negedge clk);
      chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_pc = v.pc; in_trap = v.trap; in_ctrl = v.ctrl;
      in_exe = v.exe; in_wdata = v.wdata; out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      @(negedge clk);
      cyc = 1;
      in_valid = 1'b0; in_pc = {$urandom, $urandom}; in_trap = 4'($urandom); in_ctrl = 4'($urandom);
      in_exe = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
      if (v.exp_mem) begin
         chk({tag, ".no_early_out"}, 64'(out_valid), 64'd0);
         chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
         for (int i = 0; i <= v.req_stall; i++) begin
            chk({tag, ".req_valid"}, 64'(mem_req_valid), 64'd1);
            chk({tag, ".req_addr"}, mem_req_addr, v.exp_addr);
            chk({tag, ".req_wen"}, 64'(mem_req_wen), 64'(v.exp_wen));
            if (v.exp_wen) begin
               chk({tag, ".req_wmask"}, 64'(mem_req_wmask), 64'(v.exp_wmask));
               chk({tag, ".req_wdata"}, mem_req_wdata, v.exp_wdata);
            end
            if (i < v.req_stall) begin
               @(negedge clk);
               cyc++;
            end
         end
         mem_req_ready = 1'b1;
         @(negedge clk);
         cyc++;
         mem_req_ready = 1'b0;
         chk({tag, ".req_dropped"}, 64'(mem_req_valid), 64'd0);
         for (int i = 1; i < v.rsp_wait; i++) begin
            @(negedge clk);
            cyc++;
            chk({tag, ".wait_no_out"}, 64'(out_valid), 64'd0);
         end
         mem_rsp_valid = 1'b1;
         mem_rsp_rdata = v.rdata;
         @(negedge clk);
         cyc++;
         mem_rsp_valid = 1'b0;
         mem_rsp_rdata = {$urandom, $urandom};
      end else begin
         chk({tag, ".no_request"}, 64'(mem_req_valid), 64'd0);
      end
      exp_lat = v.exp_mem ? (2 + v.req_stall + v.rsp_wait) : 1;
      chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
      chk({tag, ".out_pc"}, out_pc, v.pc);
      chk({tag, ".out_trap"}, 64'(out_trap), 64'(v.exp_trap));
      chk({tag, ".out_data"}, out_data, v.exp_data);
      chk({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < v.out_stall; i++) begin
         @(negedge clk);
         chk({tag, ".out_held"}, 64'(out_valid), 64'd1);
         chk({tag, ".data_held"}, out_data, v.exp_data);
         chk({tag, ".in_ready_held"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".out_released"}, 64'(out_valid), 64'd0);
      chk({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      vec_t rv;
      logic [3:0] r_ctrl, r_trap;
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_pc = 64'h0; in_trap = 4'd0; in_ctrl = 4'd0;
      in_exe = 64'h0; in_wdata = 64'h0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 64'h0; out_ready = 1'b0;

      // Directed vectors: pc, trap, ctrl, exe, wdata, rdata, req_stall, rsp_wait, out_stall, expectations
      add_vec(64'h1000, 4'd0, C_LB,  64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0, 2, 0,
              1'b1, 64'h8000_0000, 1'b0, 8'h00, 64'h0, 4'd0, 64'hFFFF_FFFF_FFFF_FF80);
      add_vec(64'h1004, 4'd0, C_SH,  64'h8000_0006, 64'h1234, 64'h0, 3, 1, 0,
              1'b1, 64'h8000_0000, 1'b1, 8'hC0, 64'h1234_0000_0000_0000, 4'd0, 64'h0);
      add_vec(64'h1008, 4'd0, C_NOP, 64'h55, 64'h0, 64'h0, 0, 1, 2,
              1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 4'd0, 64'h55);
      add_vec(64'h100C, 4'd2, C_LD,  64'h8000_0000, 64'h0, 64'h0, 0, 1, 0,
              1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 4'd2, 64'h0);
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
      add_vec(64'h1010, 4'd0, C_LW,  64'h8000_0002, 64'h0, 64'h1122_3344_A5B6_C7D8, 0, 1, 0,
              1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 4'd4, 64'h0);
      add_vec(64'h1014, 4'd0, C_SD,  64'h4003, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 1, 0,
              1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 4'd6, 64'h0);
`else
      add_vec(64'h1010, 4'd0, C_LW,  64'h8000_0002, 64'h0, 64'h1122_3344_A5B6_C7D8, 0, 1, 0,
              1'b1, 64'h8000_0000, 1'b0, 8'h00, 64'h0, 4'd0, 64'hFFFF_FFFF_A5B6_C7D8);
      add_vec(64'h1014, 4'd0, C_SD,  64'h4003, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 1, 0,
              1'b1, 64'h4000, 1'b1, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 4'd0, 64'h0);
`endif
      add_vec(64'h1018, 4'd0, C_LH,  64'h3002, 64'h0, 64'h0000_0000_8765_0000, 1, 1, 0,
              1'b1, 64'h3000, 1'b0, 8'h00, 64'h0, 4'd0, 64'hFFFF_FFFF_FFFF_8765);
      add_vec(64'h101C, 4'd0, C_LHU, 64'h2006, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 1,
              1'b1, 64'h2000, 1'b0, 8'h00, 64'h0, 4'd0, 64'h0000_0000_0000_0123);
      add_vec(64'h1020, 4'd0, C_LWU, 64'h2004, 64'h0, 64'h89AB_CDEF_0123_4567, 0, 3, 0,
              1'b1, 64'h2000, 1'b0, 8'h00, 64'h0, 4'd0, 64'h0000_0000_89AB_CDEF);
      add_vec(64'h1024, 4'd0, C_SB,  64'h4005, 64'hAB, 64'h0, 0, 1, 0,
              1'b1, 64'h4000, 1'b1, 8'h20, 64'h0000_AB00_0000_0000, 4'd0, 64'h0);
      add_vec(64'h1028, 4'd0, C_SW,  64'h4004, 64'h1122_3344, 64'h0, 0, 1, 0,
              1'b1, 64'h4000, 1'b1, 8'hF0, 64'h1122_3344_0000_0000, 4'd0, 64'h0);
      add_vec(64'h102C, 4'd0, C_LD,  64'h8, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 1, 0,
              1'b1, 64'h8, 1'b0, 8'h00, 64'h0, 4'd0, 64'hFEDC_BA98_7654_3210);
      add_vec(64'h1030, 4'd3, C_NOP, 64'h77, 64'h0, 64'h0, 0, 1, 0,
              1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 4'd3, 64'h0);

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst.req_addr", mem_req_addr, 64'h0);
      chk("rst.req_wen", 64'(mem_req_wen), 64'd0);
      chk("rst.req_wmask", 64'(mem_req_wmask), 64'd0);
      chk("rst.req_wdata", mem_req_wdata, 64'h0);
      chk("rst.out_pc", out_pc, 64'h0);
      chk("rst.out_trap", 64'(out_trap), 64'd0);
      chk("rst.out_data", out_data, 64'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

      // Reset while in REQ drops the request
      @(negedge clk);
      in_valid = 1'b1; in_trap = 4'd0; in_ctrl = C_LD; in_exe = 64'h100; in_pc = 64'h2000;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rstreq.req_up", 64'(mem_req_valid), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rstreq.req_dropped", 64'(mem_req_valid), 64'd0);
      chk("rstreq.in_ready", 64'(in_ready), 64'd1);

      // Reset while in WAIT, then a stray response must be ignored
      in_valid = 1'b1; in_ctrl = C_LD; in_exe = 64'h200; in_pc = 64'h2004;
      @(negedge clk);
      in_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("rstwait.in_wait", 64'(mem_req_valid), 64'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1111_2222_3333_4444;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("rstwait.out_valid", 64'(out_valid), 64'd0);
      chk("rstwait.in_ready", 64'(in_ready), 64'd1);
      chk("rstwait.req_valid", 64'(mem_req_valid), 64'd0);
      @(negedge clk);
      chk("rstwait.out_valid_later", 64'(out_valid), 64'd0);
      chk("rstwait.out_data", out_data, 64'h0);
      run_op("post_rst", vecs[2]);

      // Randomized ops against the reference model
      for (int k = 0; k < 40; k++) begin
         r_ctrl = 4'($urandom_range(0, 11));
         r_trap = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         rv.pc = {$urandom, $urandom}; rv.trap = r_trap; rv.ctrl = r_ctrl;
         rv.exe = {$urandom, $urandom}; rv.wdata = {$urandom, $urandom}; rv.rdata = {$urandom, $urandom};
         rv.req_stall = $urandom_range(0, 2); rv.rsp_wait = $urandom_range(1, 3); rv.out_stall = $urandom_range(0, 2);
         model(rv.ctrl, rv.trap, rv.exe, rv.wdata, rv.rdata, rv.exp_mem, rv.exp_addr, rv.exp_wen,
               rv.exp_wmask, rv.exp_wdata, rv.exp_trap, rv.exp_data);
         run_op($sformatf("rnd%0d", k), rv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
